// File: rtl/stopwatch_bcd_counter.sv
// ---------------------------------------------------------------------------
// stopwatch_bcd_counter
//
// Stopwatch timebase plus BCD digit chain. A prescaler divides clk down to
// TICK_HZ while the run controller is in RUNNING. Each prescaler wrap bumps a
// chain of NUM_DIGITS packed BCD digits. One digit (MOD6_IDX) counts 0..5 so
// the display can read seconds:tens-of-seconds.
//
// Optional feature macro: LAP_HOLD_EN
//   Defined   : `lap` toggles a display freeze (lap hold). The live count keeps
//               running underneath.
//   Undefined : `lap` is ignored and `held` is tied to 0.
//
// Parameters
//   CLK_HZ     input clock frequency in Hz
//   TICK_HZ    count rate in Hz; CLK_HZ/TICK_HZ must be an integer >= 2
//   NUM_DIGITS number of BCD digits (1..8)
//   MOD6_IDX   digit that counts 0..5; any value >= NUM_DIGITS disables it
//   WRAP       1 = wrap to zero at full scale, 0 = saturate and pause
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   start_stop single-cycle pulse; IDLE->RUNNING, RUNNING<->PAUSED
//   clr        single-cycle pulse; zero count, clear overflow, go to IDLE
//   lap        single-cycle pulse; toggles lap hold (LAP_HOLD_EN only)
//   digits     packed BCD; digit 0 is in bits [3:0]
//   running    high while in RUNNING (registered)
//   tick       one-cycle pulse coincident with each count update
//   overflow   sticky full-scale flag
//   held       high while the display is frozen
// ---------------------------------------------------------------------------
module stopwatch_bcd_counter #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 100,
  parameter int NUM_DIGITS = 4,
  parameter int MOD6_IDX   = 3,
  parameter int WRAP       = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_stop,
  input  logic                    clr,
  input  logic                    lap,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    running,
  output logic                    tick,
  output logic                    overflow,
  output logic                    held
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [PW-1:0]           pre_reg, pre_next;
  logic [4*NUM_DIGITS-1:0] count_reg, count_next;
  logic [4*NUM_DIGITS-1:0] inc_count;
  logic                    running_reg, running_next;
  logic                    tick_reg, tick_next;
  logic                    overflow_reg, overflow_next;
  logic                    tick_int;
  logic                    full_scale;
  logic [NUM_DIGITS:0]     carry;

  // -------------------------------------------------------------------------
  // BCD increment chain.
  // carry[i] is high when every digit below i sits at its maximum, so digit i
  // advances on this tick. A digit at its maximum rolls over to 0.
  // carry[NUM_DIGITS] therefore flags full scale.
  // -------------------------------------------------------------------------
  assign carry[0] = 1'b1;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    localparam logic [3:0] DMAX = (gi == MOD6_IDX) ? 4'd5 : 4'd9;
    logic [3:0] cur;
    logic       at_max;

    assign cur       = count_reg[4*gi +: 4];
    assign at_max    = (cur == DMAX);
    assign carry[gi+1] = carry[gi] & at_max;
    assign inc_count[4*gi +: 4] = !carry[gi] ? cur :
                                  (at_max ? 4'd0 : cur + 4'd1);
  end

  assign full_scale = carry[NUM_DIGITS];

  // The internal tick fires on the cycle where the prescaler reads DIV-1.
  // Its effect (new digits, tick pulse) appears after the following edge.
  assign tick_int = (state_reg == ST_RUNNING) && (pre_reg == PRE_LAST);

  // -------------------------------------------------------------------------
  // Run controller, prescaler and count: next-state logic.
  // clr beats everything. Otherwise any tick is applied first, and then
  // start_stop toggles whatever state results from that tick.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    pre_next      = pre_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    tick_next     = 1'b0;

    if (clr) begin
      state_next    = ST_IDLE;
      pre_next      = '0;
      count_next    = '0;
      overflow_next = 1'b0;
    end else begin
      if (state_reg == ST_RUNNING) begin
        pre_next = tick_int ? '0 : pre_reg + PW'(1);
      end

      if (tick_int) begin
        tick_next = 1'b1;
        if (full_scale) begin
          overflow_next = 1'b1;
          if (WRAP != 0) begin
            count_next = '0;
          end else begin
            // Saturate. Later ticks leave the digits alone and pause again.
            state_next = ST_PAUSED;
          end
        end else begin
          count_next = inc_count;
        end
      end

      if (start_stop) begin
        state_next = (state_next == ST_RUNNING) ? ST_PAUSED : ST_RUNNING;
      end
    end

    running_next = (state_next == ST_RUNNING);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      pre_reg      <= '0;
      count_reg    <= '0;
      running_reg  <= 1'b0;
      tick_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pre_reg      <= pre_next;
      count_reg    <= count_next;
      running_reg  <= running_next;
      tick_reg     <= tick_next;
      overflow_reg <= overflow_next;
    end
  end

  assign running  = running_reg;
  assign tick     = tick_reg;
  assign overflow = overflow_reg;

`ifdef LAP_HOLD_EN
  // -------------------------------------------------------------------------
  // Lap hold. The first lap snapshots the live count as it stood before this
  // edge, and the display then shows that snapshot. The second lap releases
  // the display back to the live count. The count itself never stops.
  // -------------------------------------------------------------------------
  logic                    held_reg, held_next;
  logic [4*NUM_DIGITS-1:0] hold_reg, hold_next;

  always_comb begin
    held_next = held_reg;
    hold_next = hold_reg;
    if (clr) begin
      held_next = 1'b0;
      hold_next = '0;
    end else if (lap && (state_reg != ST_IDLE)) begin
      held_next = !held_reg;
      if (!held_reg) begin
        hold_next = count_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held_reg <= 1'b0;
      hold_reg <= '0;
    end else begin
      held_reg <= held_next;
      hold_reg <= hold_next;
    end
  end

  assign digits = held_reg ? hold_reg : count_reg;
  assign held   = held_reg;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign digits     = count_reg;
  assign held       = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_bcd_counter
//
// Drives three stopwatch instances from one set of inputs:
//   u0 : DIV=10, WRAP=1 (main timing checks)
//   u1 : DIV=2,  WRAP=1 (reaches full scale quickly)
//   u2 : DIV=2,  WRAP=0 (saturating variant)
// The reference model keeps the elapsed count as one integer (0..5999) and
// converts it to mixed-radix BCD for comparison. Compile with +define+
// LAP_HOLD_EN to exercise the lap-hold feature.
// ---------------------------------------------------------------------------
module tb_stopwatch_bcd_counter;

  localparam int NI   = 3;
  localparam int FULL = 5999;
`ifdef LAP_HOLD_EN
  localparam bit LAPEN = 1'b1;
`else
  localparam bit LAPEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_stop = 1'b0;
  logic clr = 1'b0;
  logic lap = 1'b0;

  logic [15:0]   dg [NI];
  logic [NI-1:0] run;
  logic [NI-1:0] tk;
  logic [NI-1:0] ovf;
  logic [NI-1:0] hld;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stopwatch_bcd_counter #(.CLK_HZ(1000), .TICK_HZ(100), .NUM_DIGITS(4),
                          .MOD6_IDX(3), .WRAP(1)) u0 (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clr(clr), .lap(lap),
    .digits(dg[0]), .running(run[0]), .tick(tk[0]), .overflow(ovf[0]),
    .held(hld[0]));

  stopwatch_bcd_counter #(.CLK_HZ(200), .TICK_HZ(100), .NUM_DIGITS(4),
                          .MOD6_IDX(3), .WRAP(1)) u1 (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clr(clr), .lap(lap),
    .digits(dg[1]), .running(run[1]), .tick(tk[1]), .overflow(ovf[1]),
    .held(hld[1]));

  stopwatch_bcd_counter #(.CLK_HZ(200), .TICK_HZ(100), .NUM_DIGITS(4),
                          .MOD6_IDX(3), .WRAP(0)) u2 (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clr(clr), .lap(lap),
    .digits(dg[2]), .running(run[2]), .tick(tk[2]), .overflow(ovf[2]),
    .held(hld[2]));

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;
  int m_div  [NI] = '{10, 2, 2};
  bit m_wrap [NI] = '{1'b1, 1'b1, 1'b0};
  int m_st   [NI];
  int m_pre  [NI];
  int m_n    [NI];
  int m_hold [NI];
  bit m_ovf  [NI];
  bit m_tk   [NI];
  bit m_held [NI];

  function automatic logic [15:0] bcd(input int n);
    logic [15:0] r;
    r[3:0]   = 4'(n % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[15:12] = 4'((n / 1000) % 6);
    return r;
  endfunction

  function automatic logic [19:0] exp_vec(input int k);
    logic [15:0] shown;
    shown = m_held[k] ? bcd(m_hold[k]) : bcd(m_n[k]);
    return {shown, m_st[k] == M_RUN, m_tk[k], m_ovf[k], m_held[k]};
  endfunction

  function automatic logic [19:0] act_vec(input int k);
    return {dg[k], run[k], tk[k], ovf[k], hld[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_st[k] = M_IDLE; m_pre[k] = 0; m_n[k] = 0; m_hold[k] = 0;
      m_ovf[k] = 0; m_tk[k] = 0; m_held[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      int st_old, n_old, nst;
      st_old = m_st[k];
      n_old  = m_n[k];
      m_tk[k] = 0;
      if (clr) begin
        m_st[k] = M_IDLE; m_pre[k] = 0; m_n[k] = 0; m_ovf[k] = 0;
        m_held[k] = 0; m_hold[k] = 0;
      end else begin
        nst = st_old;
        if (st_old == M_RUN) begin
          if (m_pre[k] == m_div[k] - 1) begin
            m_pre[k] = 0;
            m_tk[k]  = 1;
            if (n_old == FULL) begin
              m_ovf[k] = 1;
              if (m_wrap[k]) m_n[k] = 0;
              else nst = M_PAUSE;
            end else begin
              m_n[k] = n_old + 1;
            end
          end else begin
            m_pre[k] = m_pre[k] + 1;
          end
        end
        if (LAPEN && lap && st_old != M_IDLE) begin
          if (!m_held[k]) m_hold[k] = n_old;
          m_held[k] = !m_held[k];
        end
        if (start_stop) nst = (nst == M_RUN) ? M_PAUSE : M_RUN;
        m_st[k] = nst;
      end
    end
  endtask

  // One clock: the model follows the DUT at the edge, outputs settle by #1.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1; cyc(); clr = 1'b0;
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1; cyc(); start_stop = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    #3;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (act_vec(k) !== 20'h0) begin
        errors++;
        $display("FAIL reset_state u%0d: got %h expected %h", k, act_vec(k), 20'h0);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    $display("test_reset: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_first_tick();
    pulse_ss();
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (i == 9) begin
        checks++;
        if (tk[0] !== 1'b0 || dg[0] !== 16'h0000) begin
          errors++;
          $display("FAIL early_tick: tick=%b digits=%h expected tick=0 digits=0000", tk[0], dg[0]);
        end
      end
    end
    checks++;
    if (tk[0] !== 1'b1 || dg[0] !== 16'h0001 || run[0] !== 1'b1) begin
      errors++;
      $display("FAIL first_tick: tick=%b digits=%h running=%b expected 1/0001/1", tk[0], dg[0], run[0]);
    end
    repeat (90) cyc();
    checks++;
    if (dg[0] !== 16'h0010) begin
      errors++;
      $display("FAIL ten_ticks: digits=%h expected 0010", dg[0]);
    end
    $display("test_first_tick: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_pause();
    bit saw_tick;
    pulse_clr();
    pulse_ss();
    repeat (14) cyc();
    pulse_ss();
    checks++;
    if (dg[0] !== 16'h0001 || run[0] !== 1'b0) begin
      errors++;
      $display("FAIL pause_entry: digits=%h running=%b expected 0001/0", dg[0], run[0]);
    end
    saw_tick = 1'b0;
    repeat (50) begin
      cyc();
      if (tk[0]) saw_tick = 1'b1;
    end
    checks++;
    if (dg[0] !== 16'h0001 || saw_tick) begin
      errors++;
      $display("FAIL pause_hold: digits=%h saw_tick=%b expected 0001/0", dg[0], saw_tick);
    end
    pulse_ss();
    for (int i = 1; i <= 5; i++) begin
      cyc();
      if (i == 4) begin
        checks++;
        if (tk[0] !== 1'b0) begin
          errors++;
          $display("FAIL resume_early: tick=%b expected 0", tk[0]);
        end
      end
    end
    checks++;
    if (tk[0] !== 1'b1 || dg[0] !== 16'h0002) begin
      errors++;
      $display("FAIL resume_tick: tick=%b digits=%h expected 1/0002", tk[0], dg[0]);
    end
    $display("test_pause: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_full_scale();
    pulse_clr();
    pulse_ss();
    repeat (11996) cyc();
    checks++;
    if (dg[1] !== 16'h5998 || dg[2] !== 16'h5998) begin
      errors++;
      $display("FAIL preload: u1=%h u2=%h expected 5998", dg[1], dg[2]);
    end
    repeat (2) cyc();
    checks++;
    if (dg[1] !== 16'h5999 || dg[2] !== 16'h5999 || ovf[1] !== 1'b0) begin
      errors++;
      $display("FAIL near_full: u1=%h u2=%h ovf1=%b expected 5999/5999/0", dg[1], dg[2], ovf[1]);
    end
    repeat (2) cyc();
    checks++;
    if (dg[1] !== 16'h0000 || ovf[1] !== 1'b1 || run[1] !== 1'b1) begin
      errors++;
      $display("FAIL wrap: digits=%h ovf=%b running=%b expected 0000/1/1", dg[1], ovf[1], run[1]);
    end
    checks++;
    if (dg[2] !== 16'h5999 || ovf[2] !== 1'b1 || run[2] !== 1'b0) begin
      errors++;
      $display("FAIL saturate: digits=%h ovf=%b running=%b expected 5999/1/0", dg[2], ovf[2], run[2]);
    end
    pulse_ss();
    repeat (3) cyc();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (act_vec(k) !== exp_vec(k)) begin
        errors++;
        $display("FAIL post_full u%0d: got %h expected %h", k, act_vec(k), exp_vec(k));
      end
    end
    checks++;
    if (dg[2] !== 16'h5999) begin
      errors++;
      $display("FAIL saturate_rerun: digits=%h expected 5999", dg[2]);
    end
    $display("test_full_scale: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_clr_priority();
    pulse_clr();
    pulse_ss();
    repeat (1230) cyc();
    checks++;
    if (dg[0] !== 16'h0123 || run[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_clr: digits=%h running=%b expected 0123/1", dg[0], run[0]);
    end
    clr = 1'b1; start_stop = 1'b1;
    cyc();
    clr = 1'b0; start_stop = 1'b0;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (act_vec(k) !== 20'h0) begin
        errors++;
        $display("FAIL clr_priority u%0d: got %h expected %h", k, act_vec(k), 20'h0);
      end
    end
    $display("test_clr_priority: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_async_reset();
    pulse_clr();
    pulse_ss();
    repeat (4560) cyc();
    checks++;
    if (dg[0] !== 16'h0456) begin
      errors++;
      $display("FAIL pre_reset: digits=%h expected 0456", dg[0]);
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (act_vec(k) !== 20'h0) begin
        errors++;
        $display("FAIL async_reset u%0d: got %h expected %h", k, act_vec(k), 20'h0);
      end
    end
    #2;
    reset = 1'b1;
    repeat (30) cyc();
    checks++;
    if (dg[0] !== 16'h0000 || run[0] !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: digits=%h running=%b expected 0000/0", dg[0], run[0]);
    end
    pulse_ss();
    repeat (10) cyc();
    checks++;
    if (dg[0] !== 16'h0001) begin
      errors++;
      $display("FAIL restart: digits=%h expected 0001", dg[0]);
    end
    $display("test_async_reset: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_lap();
    logic [15:0] exp_frozen;
    pulse_clr();
    pulse_ss();
    repeat (420) cyc();
    checks++;
    if (dg[0] !== 16'h0042) begin
      errors++;
      $display("FAIL lap_pre: digits=%h expected 0042", dg[0]);
    end
    lap = 1'b1; cyc(); lap = 1'b0;
    checks++;
    if (dg[0] !== 16'h0042 || hld[0] !== LAPEN) begin
      errors++;
      $display("FAIL lap_first: digits=%h held=%b expected 0042/%b", dg[0], hld[0], LAPEN);
    end
    repeat (649) cyc();
    exp_frozen = LAPEN ? 16'h0042 : 16'h0107;
    checks++;
    if (dg[0] !== exp_frozen || hld[0] !== LAPEN || tk[0] !== 1'b1) begin
      errors++;
      $display("FAIL lap_frozen: digits=%h held=%b tick=%b expected %h/%b/1", dg[0], hld[0], tk[0], exp_frozen, LAPEN);
    end
    lap = 1'b1; cyc(); lap = 1'b0;
    checks++;
    if (dg[0] !== 16'h0107 || hld[0] !== 1'b0) begin
      errors++;
      $display("FAIL lap_release: digits=%h held=%b expected 0107/0", dg[0], hld[0]);
    end
    $display("test_lap: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_random();
    pulse_clr();
    for (int i = 0; i < 4000; i++) begin
      start_stop = ($urandom_range(0, 39) == 0);
      clr        = ($urandom_range(0, 399) == 0);
      lap        = ($urandom_range(0, 29) == 0);
      cyc();
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (act_vec(k) !== exp_vec(k)) begin
          errors++;
          if (errors < 40)
            $display("FAIL random cyc%0d u%0d: got %h expected %h", i, k, act_vec(k), exp_vec(k));
        end
      end
    end
    start_stop = 1'b0; clr = 1'b0; lap = 1'b0;
    $display("test_random: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_pause();
    test_full_scale();
    test_clr_priority();
    test_async_reset();
    test_lap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd_counter.md
Name: stopwatch_bcd_counter

Overview:
Parametrised stopwatch timebase and BCD digit chain. Divides the system clock to a tick rate and counts ticks into NUM_DIGITS packed BCD digits, with a mixed-radix digit for tens-of-seconds. A single-pulse start/stop toggle and a clear drive a three-state run controller. Sits between the debounced button logic and the seven-segment display multiplexer.

Parameters:
CLK_HZ, 100_000_000, input clock frequency in Hz
TICK_HZ, 100, count rate in Hz; DIV = CLK_HZ/TICK_HZ, integer and >= 2
NUM_DIGITS, 4, number of BCD digits, 1..8
MOD6_IDX, 3, index of the digit that counts 0..5; values >= NUM_DIGITS disable it
WRAP, 1, 1 = wrap to zero at full scale; 0 = saturate and pause

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous active-low reset
start_stop  in  1  single-cycle pulse, debounced upstream; toggles run/pause
clr  in  1  single-cycle pulse; zeroes count and returns to IDLE
lap  in  1  single-cycle pulse; lap hold toggle, used only with LAP_HOLD_EN
digits  out  4*NUM_DIGITS  packed BCD, digit 0 in bits [3:0] (least significant)
running  out  1  high in RUNNING state
tick  out  1  one-cycle pulse, concurrent with each digits increment
overflow  out  1  sticky full-scale flag
held  out  1  high while the display is frozen (0 without LAP_HOLD_EN)

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, prescaler 0, all digits 0, running 0, tick 0, overflow 0, held 0.
- States:
  - IDLE -start_stop-> RUNNING.
  - RUNNING -start_stop-> PAUSED.
  - PAUSED -start_stop-> RUNNING.
  - Any state -clr-> IDLE.
- Prescaler: width $clog2(DIV). Increments only in RUNNING. At DIV-1 it wraps to 0 and raises the internal tick. Holds its value in PAUSED, so the fractional period is preserved across a pause. Zeroed by clr.
- Digit update:
  - Registered. digits changes and tick pulses the clk edge after prescaler==DIV-1 is sampled.
  - First tick arrives DIV cycles after the start_stop pulse when starting from IDLE.
- BCD chain:
  - Digit i increments when all lower digits are at max.
  - Max is 9, or 5 for digit MOD6_IDX. A digit at max rolls to 0 and carries.
  - Digits never hold values above their max.
- Full scale (all digits at max, tick):
  - WRAP=1: all digits become 0 and overflow is set; state stays RUNNING.
  - WRAP=0: digits hold at full scale, overflow is set, state goes to PAUSED. Further start_stop re-enters RUNNING, but ticks do not change digits.
- overflow is cleared only by clr or reset.
- Priority:
  - clr overrides start_stop, a tick and lap in the same cycle. Result: IDLE, zero count, no tick pulse.
  - start_stop arriving on the same cycle as a tick: the tick is applied, and the state toggles after it.
- running is a registered state decode and changes the cycle after start_stop.
- Inputs that are high for more than one cycle are treated as repeated pulses. Edge detection is not this block's job.

Optional Feature:
LAP_HOLD_EN.
- Defined:
  - A digits_hold register sits in front of digits.
  - lap in RUNNING or PAUSED toggles held. On the first lap, digits_hold captures the live count; while held=1, digits shows digits_hold.
  - The internal count and tick continue unaffected.
  - lap in IDLE is ignored.
  - clr clears held.
  - tick still pulses while held.
- Undefined: lap is ignored, held is tied to 0, and digits always shows the live count.

Test Plan:
1. CLK_HZ=1000, TICK_HZ=100 (DIV=10), start_stop at cycle 0 -> first tick and digits=0x0001 at cycle 10; digits=0x0010 after 10 ticks.
2. Start, pause after 15 cycles, idle 50 cycles, resume -> digits stays 0x0001 while paused; next tick comes 5 cycles after resume (prescaler preserved).
3. Preload near full scale by running to 0x5998, WRAP=1 -> next tick gives 0x5999; the one after gives 0x0000 with overflow=1 and running=1. With WRAP=0: holds 0x5999, running=0, overflow=1.
4. clr and start_stop in the same cycle while RUNNING at 0x0123 -> next cycle: digits=0, state IDLE, running=0, overflow=0, no tick.
5. Assert reset mid-count at 0x0456 between clock edges -> outputs zero immediately, without waiting for a clk edge. After release, a start_stop is required before counting resumes.
6. LAP_HOLD_EN: lap at 0x0042 -> digits frozen at 0x0042 and held=1 while the count advances. Second lap at internal 0x0107 -> digits=0x0107, held=0.
